trace_collector: RTL and testbench

TRACE_COLLECTOR -- requirements
Module: trace_collector

---
 rtl/trace_collector.sv | 90 +++++++++
 tb/tb_trace_collector.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/trace_collector.sv
// trace_collector: gathers kept retired instructions into a FIFO and streams them as fixed-length packets.
module trace_collector #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter int PKT_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       instr_valid,
    input  logic [PC_W-1:0]            pc,
    input  logic [INSTR_W-1:0]         instr,
    input  logic                       drop_instr,
    output logic [PC_W+INSTR_W-1:0]    m_tdata,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [31:0]                drop_count,
    output logic [31:0]                ovf_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = PC_W + INSTR_W;
    localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t        cur, nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [BW-1:0] beat_cnt;
    logic          pop, push_req, push, lose, drop_ev, start, full;

    assign state    = cur;
    assign full     = fifo_count == FULL;
    assign start    = cur == IDLE && enable;
    assign m_tvalid = fifo_count != '0;
    assign m_tdata  = mem[rd_ptr];
    // Gated by m_tvalid so tlast never asserts on an empty FIFO (including during reset).
    assign m_tlast  = m_tvalid && (beat_cnt == LAST || (cur == DRAIN && fifo_count == (AW+1)'(1)));
    assign pop      = m_tvalid && m_tready;
    assign push_req = cur == RUN && instr_valid && !drop_instr;
    assign push     = push_req && (!full || pop);
    assign lose     = push_req && full && !pop;
    assign drop_ev  = cur == RUN && instr_valid && drop_instr;

    // Session FSM: DRAIN ignores enable and only leaves once the FIFO is empty.
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (enable) nxt = RUN;
            RUN:     if (!enable) nxt = DRAIN;
            DRAIN:   if (fifo_count == '0) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, pointers, occupancy, beat position and session statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            beat_cnt   <= '0;
            drop_count <= '0;
            ovf_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            cur        <= nxt;
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            beat_cnt   <= start ? '0 : pop ? (m_tlast ? '0 : beat_cnt + 1'b1) : beat_cnt;
            drop_count <= start ? '0 : (drop_ev && drop_count != '1) ? drop_count + 32'd1 : drop_count;
            ovf_count  <= start ? '0 : (lose && ovf_count != '1) ? ovf_count + 32'd1 : ovf_count;
            overflow   <= start ? 1'b0 : overflow | lose;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pc, instr};
    end
endmodule

// File: tb/tb_trace_collector.sv
// tb_trace_collector: scoreboard bench for trace_collector with a cycle-level expectation model.
module tb_trace_collector;
    localparam int PC_W = 64, INSTR_W = 32, DEPTH = 16, PKT_LEN = 8;

    logic                    clk = 1'b0, rst_n = 1'b0, enable = 1'b0, instr_valid = 1'b0;
    logic [PC_W-1:0]         pc = '0;
    logic [INSTR_W-1:0]      instr = '0;
    logic                    drop_instr = 1'b0, m_tready = 1'b0;
    logic [PC_W+INSTR_W-1:0] m_tdata;
    logic                    m_tvalid, m_tlast, overflow;
    logic [1:0]              state;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [31:0]             drop_count, ovf_count;

    int n_vec = 0, n_err = 0;
    logic [PC_W+INSTR_W-1:0] q[$];
    int mstate = 0, mbeat = 0, pop_idx = 0, n;
    logic [31:0] last_mask = '0;

    trace_collector #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .instr_valid(instr_valid), .pc(pc),
        .instr(instr), .drop_instr(drop_instr), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .state(state), .fifo_count(fifo_count),
        .drop_count(drop_count), .ovf_count(ovf_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model before the edge, then advance the model.
    task automatic cycle();
        int  sz0;
        bit  last;
        sz0 = q.size();
        check("state", 128'(state), 128'(mstate));
        check("tvalid", 128'(m_tvalid), 128'(sz0 != 0));
        check("count", 128'(fifo_count), 128'(sz0));
        if (sz0 != 0 && m_tready) begin
            last = (mbeat == PKT_LEN - 1) || (mstate == 2 && sz0 == 1);
            check("tdata", 128'(m_tdata), 128'(q[0]));
            check("tlast", 128'(m_tlast), 128'(last));
            if (m_tlast && pop_idx < 32) last_mask[pop_idx] = 1'b1;
            pop_idx++;
            void'(q.pop_front());
            mbeat = last ? 0 : mbeat + 1;
        end
        if (mstate == 1 && instr_valid && !drop_instr && q.size() < DEPTH) q.push_back({pc, instr});
        case (mstate)
            0: if (enable) begin mstate = 1; mbeat = 0; end
            1: if (!enable) mstate = 2;
            default: if (sz0 == 0) mstate = 0;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input bit v, input bit d);
        instr_valid = v;
        drop_instr  = d;
        pc          = {$urandom, $urandom};
        instr       = $urandom;
        cycle();
    endtask

    task automatic drain_to_idle();
        n = 0;
        while (state != 2'd0 && n < 60) begin
            cycle();
            n++;
        end
        check("idle_reached", 128'(state), 128'(0));
    endtask

    initial begin
        #1;
        check("rst_state", 128'(state), 128'(0));
        check("rst_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_tlast", 128'(m_tlast), 128'(0));
        check("rst_count", 128'(fifo_count), 128'(0));
        check("rst_drop", 128'(drop_count), 128'(0));
        check("rst_ovf", 128'({ovf_count, overflow}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Instructions in IDLE are ignored.
        for (int i = 0; i < 3; i++) drv(1, i[0]);
        check("idle_drop", 128'(drop_count), 128'(0));

        // Mixed keep/drop with a stalled sink.
        instr_valid = 1'b0; enable = 1'b1; m_tready = 1'b0;
        cycle();
        drv(1, 0); drv(1, 1); drv(1, 0); drv(1, 1); drv(1, 0);
        check("s1_count", 128'(fifo_count), 128'(3));
        check("s1_drop", 128'(drop_count), 128'(2));
        check("s1_head", 128'(m_tdata), 128'(q[0]));
        enable = 1'b0; m_tready = 1'b1; instr_valid = 1'b1;
        drain_to_idle();
        check("s1_drop_hold", 128'(drop_count), 128'(2));

        // Overflow, then a push that coincides with a pop while full.
        enable = 1'b1; m_tready = 1'b0; instr_valid = 1'b0;
        cycle();
        check("s2_drop_clr", 128'(drop_count), 128'(0));
        for (int i = 0; i < 20; i++) drv(1, 0);
        check("s2_count", 128'(fifo_count), 128'(16));
        check("s2_ovf", 128'(ovf_count), 128'(4));
        check("s2_flag", 128'(overflow), 128'(1));
        m_tready = 1'b1;
        drv(1, 0);
        check("s3_count", 128'(fifo_count), 128'(16));
        check("s3_ovf", 128'(ovf_count), 128'(4));
        enable = 1'b0; instr_valid = 1'b0;
        drain_to_idle();

        // Packetisation: tlast on beat 8 and on the final drain beat.
        enable = 1'b1; m_tready = 1'b0;
        cycle();
        for (int i = 0; i < 10; i++) drv(1, 0);
        enable = 1'b0; instr_valid = 1'b0; m_tready = 1'b1;
        last_mask = '0; pop_idx = 0;
        cycle();
        check("s4_drain", 128'(state), 128'(2));
        drain_to_idle();
        check("s4_lastmask", 128'(last_mask), 128'(32'h280));
        check("s4_beats", 128'(pop_idx), 128'(10));

        // Asynchronous reset mid-session.
        enable = 1'b1; m_tready = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) drv(1, i == 2 || i == 5);
        check("s5_count", 128'(fifo_count), 128'(6));
        #2 rst_n = 1'b0;
        #1;
        check("s5_tvalid", 128'(m_tvalid), 128'(0));
        check("s5_state", 128'(state), 128'(0));
        check("s5_count0", 128'(fifo_count), 128'(0));
        check("s5_cnts", 128'({drop_count, ovf_count, overflow}), 128'(0));
        q.delete(); mstate = 0; mbeat = 0;
        instr_valid = 1'b0; enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // enable 1->0->1 with pending entries: DRAIN completes, IDLE visited, RUN re-entered.
        enable = 1'b1;
        cycle();
        drv(1, 0); drv(1, 0); drv(1, 1); drv(1, 0);
        check("s6_drop", 128'(drop_count), 128'(1));
        enable = 1'b0; instr_valid = 1'b0; m_tready = 1'b1;
        cycle();
        check("s6_drain", 128'(state), 128'(2));
        enable = 1'b1;
        drain_to_idle();
        cycle();
        check("s6_run", 128'(state), 128'(1));
        check("s6_clr", 128'({drop_count, ovf_count, overflow}), 128'(0));
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
